flow_led_ctrl: RTL and testbench
================================

// Module: flow_led_ctrl
// PURPOSE
//   Parametrised LED pattern engine, successor to the fixed two-LED flow block.
//   Drives LED_NUM LEDs from one step timer with four runtime-selectable modes:
//   rotate left, rotate right, bounce and blink.
//   Adds runtime speed scaling, a pause control and a step strobe.
//   Sits directly behind board LED pins; controls come from switches or a
//   register block in the same clock domain.
// PARAMETERS
//   LED_NUM      4           number of LEDs, >=1
//   STEP_CYCLES  25_000_000  sys_clk cycles per step at speed=0, >=16
//   CNT_W        25          step counter width, must hold STEP_CYCLES-1
// PORTS
//   sys_clk    in   1        system clock
//   sys_rst    in   1        async reset, active-high
//   mode       in   2        0 rot-left, 1 rot-right, 2 bounce, 3 blink
//   speed      in   2        step period = STEP_CYCLES >> speed
//   pause      in   1        1 = freeze counter and pattern
//   led        out  LED_NUM  LED drive, 1 = on
//   step_tick  out  1        1-cycle pulse on each pattern update
// BEHAVIOUR
// - Interface: one clock, sys_clk. Reset sys_rst is asynchronous, active-high.
//   While sys_rst=1:
//   led=1 (bit0 only), cnt=0, dir=up, mode_q=0, step_tick=0.
//   Deassertion is taken on the next sys_clk edge.
// - Period P = STEP_CYCLES >> speed, computed combinationally, width CNT_W.
// - Counter: if pause=1, cnt holds. Otherwise:
//   - when cnt >= P-1 (">=" covers a speed change shrinking P): cnt<=0 and tick=1.
//   - else cnt<=cnt+1.
// - step_tick is registered and high for exactly the cycle after the edge on
//   which led changes; it is never high while pause=1.
// - On tick:
//   - if mode != mode_q: mode_q<=mode, dir<=up, and led reloads to the init
//     pattern (modes 0-2: bit0 only; mode 3: all ones). No advance that step.
//   - else advance per mode_q:
//     - 0: led <= {led[N-2:0], led[N-1]}  (rotate left, wraps MSB->bit0)
//     - 1: led <= {led[0], led[N-1:1]}    (rotate right, wraps bit0->MSB)
//     - 2: one-hot walk. dir=up shifts left and dir=down shifts right.
//       Reaching bit N-1 sets dir=down; reaching bit0 sets dir=up.
//       End LEDs are shown once per sweep, not repeated.
//     - 3: led <= ~led  (all on / all off)
// - mode is sampled only on tick; changes between ticks have no effect until
//   the next tick.
// - LED_NUM=1: modes 0-2 hold led=1; mode 3 toggles.
// - pause mid-period: the remaining count is preserved; release resumes it
//   with no extra or lost tick.
// - Simultaneous mode change and speed change: the reload uses the new mode;
//   the period uses the new speed from that cycle.
// - Reset mid-pattern: led returns to 1 immediately (async), independent of
//   sys_clk.
// TESTING  (LED_NUM=4, STEP_CYCLES=16)
//   1. Reset, mode=0, speed=0 -> led 0001,0010,0100,1000,0001 at 16-cycle
//      steps; step_tick every 16 cycles.
//   2. mode=2 from reset -> first tick reloads 0001, then 0010,0100,1000,
//      0100,0010,0001,0010.
//   3. mode 0->1 applied at cnt=5 while led=0100 -> led holds 0100 until the
//      tick, reloads 0001, next step gives 1000.
//   4. mode=3 -> reload 1111, then 0000, then 1111 at 16-cycle steps.
//   5. speed 0->3 at cnt=10 -> tick on the next edge, then a step every
//      2 cycles.
//   6. pause=1 for 40 cycles at cnt=7 -> led, cnt frozen, no step_tick;
//      after release the tick lands 9 cycles later.
//   7. Assert sys_rst asynchronously mid-step with led=1000 -> led=0001
//      before the next clock edge; step_tick=0.

Source files
------------

// File: rtl/flow_led_ctrl.sv
// flow_led_ctrl: LED pattern engine driven by one step timer.
// Modes: rotate left, rotate right, bounce (one-hot walk), blink.
// Speed scales the step period by a right shift; pause freezes everything.
module flow_led_ctrl #(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               step_tick
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [CNT_W-1:0]   cnt_q, cnt_d, period;
  logic [LED_NUM-1:0] led_q, led_d;
  logic [1:0]         mode_q, mode_d;
  dir_e               dir_q, dir_d;
  logic               step_tick_q, step_tick_d;
  logic               tick;
  logic [LED_NUM-1:0] rotl, rotr, shl, shr, init_pat;

  // Period shrinks with speed; ">=" below absorbs a shrink mid-period.
  assign period = CNT_W'(STEP_CYCLES >> speed);
  assign tick   = !pause && (cnt_q >= period - CNT_W'(1));

  // Per-bit neighbour taps; the modulo wrap keeps LED_NUM=1 legal.
  for (genvar i = 0; i < LED_NUM; i++) begin : g_bit
    assign rotl[i] = led_q[(i + LED_NUM - 1) % LED_NUM];
    assign rotr[i] = led_q[(i + 1) % LED_NUM];
    if (i == 0) begin : g_shl0
      assign shl[i] = 1'b0;
    end else begin : g_shln
      assign shl[i] = led_q[i-1];
    end
    if (i == LED_NUM - 1) begin : g_shrn
      assign shr[i] = 1'b0;
    end else begin : g_shr
      assign shr[i] = led_q[i+1];
    end
  end

  // Blink starts all-on; every other mode starts from bit0.
  assign init_pat = (mode == 2'd3) ? {LED_NUM{1'b1}} : LED_NUM'(1);

  // Step counter and pattern next-state.
  always_comb begin
    cnt_d       = cnt_q;
    led_d       = led_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    step_tick_d = 1'b0;
    if (!pause) begin
      if (tick) begin
        cnt_d       = '0;
        step_tick_d = 1'b1;
        if (mode != mode_q) begin
          // A mode switch spends its step on the reload.
          mode_d = mode;
          dir_d  = DIR_UP;
          led_d  = init_pat;
        end else begin
          unique case (mode_q)
            2'd0: led_d = rotl;
            2'd1: led_d = rotr;
            2'd2: begin
              if (LED_NUM == 1) begin
                led_d = led_q;
              end else if (dir_q == DIR_UP) begin
                led_d = shl;
                if (shl[LED_NUM-1]) dir_d = DIR_DOWN;
              end else begin
                led_d = shr;
                if (shr[0]) dir_d = DIR_UP;
              end
            end
            default: led_d = ~led_q;
          endcase
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers, async reset to bit0-on / idle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      led_q       <= LED_NUM'(1);
      mode_q      <= 2'd0;
      dir_q       <= DIR_UP;
      step_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign led = led_q;
  // Masked so a pause raised right after a step never shows a strobe.
  assign step_tick = step_tick_q && !pause;

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Randomized bench for flow_led_ctrl against a step-index reference model:
// the pattern is a pure function of (active mode, steps since reload).
module tb_flow_led_ctrl;
  localparam int N = 4;
  localparam int SC = 16;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic [1:0]   mode, speed;
  logic         pause;
  logic [N-1:0] led;
  logic         step_tick;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int m_cnt, m_mode, m_k;
  bit m_tick_prev;

  flow_led_ctrl #(.LED_NUM(N), .STEP_CYCLES(SC), .CNT_W(5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .speed(speed),
    .pause(pause), .led(led), .step_tick(step_tick)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_led(input int m, input int k);
    int t, pos;
    case (m)
      0: pos = k % N;
      1: pos = (N - k % N) % N;
      2: begin
        t = k % (2 * (N - 1));
        pos = (t < N) ? t : 2 * (N - 1) - t;
      end
      default: return (k % 2 == 0) ? {N{1'b1}} : '0;
    endcase
    return N'(1) << pos;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_k = 0; m_tick_prev = 0;
  endtask

  // One clock of the reference, using inputs stable across the edge.
  task automatic model_step();
    int p;
    bit t;
    p = SC >> speed;
    t = !pause && (m_cnt >= p - 1);
    if (!pause) begin
      if (t) begin
        m_cnt = 0;
        if (int'(mode) != m_mode) begin
          m_mode = int'(mode);
          m_k = 0;
        end else m_k++;
      end else m_cnt++;
    end
    m_tick_prev = t;
  endtask

  task automatic run(input int n, input bit rnd);
    repeat (n) begin
      @(posedge sys_clk);
      model_step();
      @(negedge sys_clk);
      chk("led", 32'(led), 32'(exp_led(m_mode, m_k)));
      chk("step_tick", 32'(step_tick), 32'(m_tick_prev && !pause));
      if (rnd) begin
        if ($urandom_range(39) == 0) mode = 2'($urandom);
        if ($urandom_range(59) == 0) speed = 2'($urandom);
        if (pause) begin
          if ($urandom_range(7) == 0) pause = 1'b0;
        end else if ($urandom_range(29) == 0) pause = 1'b1;
      end
    end
  endtask

  initial begin
    sys_rst = 1'b1; mode = 2'd0; speed = 2'd0; pause = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_led", 32'(led), 32'h1);
    chk("rst_tick", 32'(step_tick), 32'h0);
    sys_rst = 1'b0;
    model_reset();

    // plain rotate-left at full period
    run(80, 1'b0);
    // bounce from reload through a full sweep
    mode = 2'd2;
    run(160, 1'b0);
    // blink
    mode = 2'd3;
    run(64, 1'b0);
    // randomized mixing of mode, speed and pause
    run(2500, 1'b1);

    // get to led=1000 in rotate-left, then reset asynchronously mid-step
    mode = 2'd0; speed = 2'd3; pause = 1'b0;
    for (int i = 0; i < 40 && exp_led(m_mode, m_k) != N'(8); i++) run(1, 1'b0);
    chk("pre_rst_led", 32'(led), 32'h8);
    speed = 2'd0;
    run(1, 1'b0);
    #2 sys_rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'h1);
    chk("async_rst_tick", 32'(step_tick), 32'h0);
    @(negedge sys_clk);
    chk("rst_hold_led", 32'(led), 32'h1);
    sys_rst = 1'b0;
    model_reset();
    run(1500, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
